// File: rtl/alu_operand_stage.sv
// ID/EX stage feeding the ALU: resolves EX/WB forwarding, builds op2 from rt or the
// extended immediate, detects load-use hazards and registers the ALU operands.
module alu_operand_stage #(
    parameter int W  = 32,
    parameter int RA = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [RA-1:0] rs_addr,
    input  logic [RA-1:0] rt_addr,
    input  logic [W-1:0]  rs_data,
    input  logic [W-1:0]  rt_data,
    input  logic [15:0]   imm16,
    input  logic          imm_sel,
    input  logic          sign_ext,
    input  logic [4:0]    shamt_in,
    input  logic [4:0]    aluop_in,
    input  logic [RA-1:0] rd_addr_in,
    input  logic          regwrite_in,
    input  logic          is_load_in,
    input  logic          flush,
    input  logic          ex_we,
    input  logic          ex_load,
    input  logic [RA-1:0] ex_addr,
    input  logic [W-1:0]  ex_result,
    input  logic          wb_we,
    input  logic [RA-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    output logic [W-1:0]  op1,
    output logic [W-1:0]  op2,
    output logic [4:0]    smt,
    output logic [4:0]    aluop,
    output logic [RA-1:0] rd_addr,
    output logic          regwrite,
    output logic          is_load,
    output logic          out_valid,
    output logic          stall_req
);

    logic [W-1:0] fwd_rs;
    logic [W-1:0] fwd_rt;
    logic [W-1:0] imm_ext;
    logic         bubble;

    // A load still in EX has no data yet, so it is never a forwarding source;
    // that case is covered by the stall instead.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        fwd_rs = rs_data;
        if (rs_addr == '0)
            fwd_rs = '0;
        else if (ex_we && !ex_load && (ex_addr == rs_addr))
            fwd_rs = ex_result;
        else if (wb_we && (wb_addr == rs_addr))
            fwd_rs = wb_data;

        fwd_rt = rt_data;
        if (rt_addr == '0)
            fwd_rt = '0;
        else if (ex_we && !ex_load && (ex_addr == rt_addr))
            fwd_rt = ex_result;
        else if (wb_we && (wb_addr == rt_addr))
            fwd_rt = wb_data;
    end

    assign imm_ext = sign_ext ? {{(W-16){imm16[15]}}, imm16} : {{(W-16){1'b0}}, imm16};

    // rt only matters for the hazard when it is actually read as op2.
    assign stall_req = in_valid & ex_load & ex_we & (ex_addr != '0) &
                       ((ex_addr == rs_addr) | ((ex_addr == rt_addr) & ~imm_sel));

    // Reset, flush, stall and idle all leave the same all-zero bubble behind.
    assign bubble = rst | flush | stall_req | ~in_valid;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (bubble) begin
            op1       <= '0;
            op2       <= '0;
            smt       <= '0;
            aluop     <= '0;
            rd_addr   <= '0;
            regwrite  <= 1'b0;
            is_load   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            op1       <= fwd_rs;
            op2       <= imm_sel ? imm_ext : fwd_rt;
            smt       <= shamt_in;
            aluop     <= aluop_in;
            rd_addr   <= rd_addr_in;
            regwrite  <= regwrite_in;
            is_load   <= is_load_in;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed cases plus random stimulus, each
// cycle's expected ALU inputs queued by the driver and compared by a separate monitor.
module tb_alu_operand_stage;

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm16;
        logic        imm_sel;
        logic        sign_ext;
        logic [4:0]  shamt;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic        regwrite;
        logic        is_load;
        logic        flush;
        logic        ex_we;
        logic        ex_load;
        logic [4:0]  ex_addr;
        logic [31:0] ex_result;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } stim_t;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  smt;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic        regwrite;
        logic        is_load;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, imm_sel, sign_ext, regwrite_in, is_load_in, flush;
    logic        ex_we, ex_load, wb_we;
    logic [4:0]  rs_addr, rt_addr, shamt_in, aluop_in, rd_addr_in, ex_addr, wb_addr;
    logic [31:0] rs_data, rt_data, ex_result, wb_data;
    logic [15:0] imm16;
    logic [31:0] op1, op2;
    logic [4:0]  smt, aluop, rd_addr;
    logic        regwrite, is_load, out_valid, stall_req;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    alu_operand_stage #(.W(32), .RA(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .imm16(imm16), .imm_sel(imm_sel), .sign_ext(sign_ext),
        .shamt_in(shamt_in), .aluop_in(aluop_in), .rd_addr_in(rd_addr_in),
        .regwrite_in(regwrite_in), .is_load_in(is_load_in), .flush(flush),
        .ex_we(ex_we), .ex_load(ex_load), .ex_addr(ex_addr), .ex_result(ex_result),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .op1(op1), .op2(op2), .smt(smt), .aluop(aluop), .rd_addr(rd_addr),
        .regwrite(regwrite), .is_load(is_load), .out_valid(out_valid),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Value a source register should read: register 0 is hard zero, a completed
    // ALU result in EX is newest, then the value being written back, then the regfile.
    function automatic logic [31:0] src_value(input stim_t s, input logic [4:0] a,
                                              input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (s.ex_we && !s.ex_load && s.ex_addr == a) return s.ex_result;
        if (s.wb_we && s.wb_addr == a) return s.wb_data;
        return rf;
    endfunction

    function automatic logic model_stall(input stim_t s);
        logic reads_rt;
        reads_rt = !s.imm_sel;
        return s.in_valid && s.ex_load && s.ex_we && s.ex_addr != 0 &&
               (s.ex_addr == s.rs_addr || (reads_rt && s.ex_addr == s.rt_addr));
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        int   imm_val;
        e = '{op1: 0, op2: 0, smt: 0, aluop: 0, rd: 0, regwrite: 0, is_load: 0, valid: 0};
        if (s.rst || s.flush || model_stall(s) || !s.in_valid) return e;
        imm_val  = s.sign_ext ? (s.imm16 >= 16'h8000 ? int'(s.imm16) - 65536 : int'(s.imm16))
                              : int'(s.imm16);
        e.op1      = src_value(s, s.rs_addr, s.rs_data);
        e.op2      = s.imm_sel ? 32'(imm_val) : src_value(s, s.rt_addr, s.rt_data);
        e.smt      = s.shamt;
        e.aluop    = s.aluop;
        e.rd       = s.rd;
        e.regwrite = s.regwrite;
        e.is_load  = s.is_load;
        e.valid    = 1'b1;
        return e;
    endfunction

    // A valid instruction with no forwarding, hazard, flush or reset activity.
    function automatic stim_t quiet_stim();
        stim_t s;
        s.rst = 0; s.in_valid = 1; s.flush = 0;
        s.rs_addr = 5'($urandom_range(1, 31)); s.rt_addr = 5'($urandom_range(1, 31));
        s.rs_data = $urandom; s.rt_data = $urandom; s.imm16 = 16'($urandom);
        s.imm_sel = 1'($urandom); s.sign_ext = 1'($urandom);
        s.shamt = 5'($urandom); s.aluop = 5'($urandom_range(1, 31)); s.rd = 5'($urandom);
        s.regwrite = 1'($urandom); s.is_load = 1'($urandom);
        s.ex_we = 0; s.ex_load = 0; s.ex_addr = 0; s.ex_result = $urandom;
        s.wb_we = 0; s.wb_addr = 0; s.wb_data = $urandom;
        return s;
    endfunction

    // Small address range so forwarding and hazard matches occur often.
    function automatic stim_t rand_stim();
        stim_t s;
        s = quiet_stim();
        s.rs_addr = 5'($urandom_range(0, 7)); s.rt_addr = 5'($urandom_range(0, 7));
        s.in_valid = ($urandom_range(0, 9) != 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.rst = ($urandom_range(0, 29) == 0);
        s.ex_we = 1'($urandom); s.ex_load = 1'($urandom); s.ex_addr = 5'($urandom_range(0, 7));
        s.wb_we = 1'($urandom); s.wb_addr = 5'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; in_valid = s.in_valid; rs_addr = s.rs_addr; rt_addr = s.rt_addr;
        rs_data = s.rs_data; rt_data = s.rt_data; imm16 = s.imm16; imm_sel = s.imm_sel;
        sign_ext = s.sign_ext; shamt_in = s.shamt; aluop_in = s.aluop; rd_addr_in = s.rd;
        regwrite_in = s.regwrite; is_load_in = s.is_load; flush = s.flush;
        ex_we = s.ex_we; ex_load = s.ex_load; ex_addr = s.ex_addr; ex_result = s.ex_result;
        wb_we = s.wb_we; wb_addr = s.wb_addr; wb_data = s.wb_data;
    endtask

    // Drive one cycle away from the active edge and queue what the ALU should see next.
    task automatic issue(input stim_t s);
        @(negedge clk);
        apply(s);
        #1;
        check("stall_req", 32'(stall_req), 32'(model_stall(s)));
        exp_q.push_back(model(s));
    endtask

    // Monitor: one registered result per edge, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("op1", op1, e.op1);
                check("op2", op2, e.op2);
                check("smt", 32'(smt), 32'(e.smt));
                check("aluop", 32'(aluop), 32'(e.aluop));
                check("rd_addr", 32'(rd_addr), 32'(e.rd));
                check("regwrite", 32'(regwrite), 32'(e.regwrite));
                check("is_load", 32'(is_load), 32'(e.is_load));
                check("out_valid", 32'(out_valid), 32'(e.valid));
            end
        end
    end

    initial begin
        stim_t s;
        apply(quiet_stim());
        rst = 1'b1;

        // Reset held two cycles with a valid instruction present, then released.
        s = quiet_stim(); s.rst = 1; issue(s);
        s = quiet_stim(); s.rst = 1; issue(s);
        issue(quiet_stim());

        // Immediate extension, both signednesses and the 0x8000 boundary.
        s = quiet_stim(); s.aluop = 5'd1; s.rs_addr = 5'd3; s.rs_data = 32'h10;
        s.imm_sel = 1; s.imm16 = 16'hFFFE; s.sign_ext = 1; issue(s);
        s.sign_ext = 0; issue(s);
        s.imm16 = 16'h8000; s.sign_ext = 1; issue(s);
        s.sign_ext = 0; issue(s);

        // Forwarding priority and the register-0 exclusion.
        s = quiet_stim(); s.rs_addr = 5'd5;
        s.ex_we = 1; s.ex_addr = 5'd5; s.ex_result = 32'hAA;
        s.wb_we = 1; s.wb_addr = 5'd5; s.wb_data = 32'hBB; issue(s);
        s.ex_we = 0; issue(s);
        s.ex_we = 1; s.rs_addr = 0; s.ex_addr = 0; s.wb_addr = 0; issue(s);

        // Load-use on rt, then the same load with op2 from the immediate.
        s = quiet_stim(); s.ex_load = 1; s.ex_we = 1; s.ex_addr = 5'd7;
        s.rt_addr = 5'd7; s.rs_addr = 5'd2; s.imm_sel = 0; issue(s);
        s.imm_sel = 1; issue(s);
        s.rs_addr = 5'd7; issue(s);

        // Flush, alone and together with a hazard.
        s = quiet_stim(); s.regwrite = 1; s.flush = 1; issue(s);
        s.ex_load = 1; s.ex_we = 1; s.ex_addr = s.rs_addr; issue(s);

        // Back-to-back clean instructions.
        for (int i = 0; i < 4; i++) issue(quiet_stim());

        // Stall with reset on top.
        s = quiet_stim(); s.ex_load = 1; s.ex_we = 1; s.ex_addr = s.rs_addr; s.rst = 1; issue(s);

        for (int i = 0; i < 400; i++) issue(rand_stim());

        @(negedge clk);
        apply(quiet_stim());
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Captures decoded instruction fields and register-file read data.
- Resolves forwarding from the EX and WB stages, builds op2 from either rt or the extended immediate, and detects load-use hazards.
- Drives registered op1, op2, smt and aluop straight into the ALU, one cycle after issue.

Parameters:
- W, 32, datapath width
- RA, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode presents an instruction this cycle
- rs_addr  in  RA  source register 1 index
- rt_addr  in  RA  source register 2 index
- rs_data  in  W  register-file value of rs
- rt_data  in  W  register-file value of rt
- imm16  in  16  instruction immediate
- imm_sel  in  1  1: op2 = extended immediate; 0: op2 = forwarded rt
- sign_ext  in  1  1: sign-extend imm16; 0: zero-extend
- shamt_in  in  5  shift amount field
- aluop_in  in  5  ALU control code
- rd_addr_in  in  RA  destination register
- regwrite_in  in  1  instruction writes rd
- is_load_in  in  1  instruction is a load
- flush  in  1  kill the instruction being captured (branch taken)
- ex_we  in  1  instruction in EX writes back
- ex_load  in  1  instruction in EX is a load
- ex_addr  in  RA  EX destination
- ex_result  in  W  ALU r1 of instruction in EX
- wb_we  in  1  WB write enable
- wb_addr  in  RA  WB destination
- wb_data  in  W  WB data
- op1  out  W  ALU operand 1 (registered)
- op2  out  W  ALU operand 2 (registered)
- smt  out  5  ALU shift amount (registered)
- aluop  out  5  ALU control (registered)
- rd_addr  out  RA  destination passed down (registered)
- regwrite  out  1  write enable passed down (registered)
- is_load  out  1  load flag passed down (registered)
- out_valid  out  1  registered stage holds a real instruction
- stall_req  out  1  combinational; decode and PC must hold this cycle

Behaviour:
- Reset (rst=1 at a clock edge):
  - op1, op2, smt, aluop, rd_addr all cleared to 0.
  - regwrite, is_load, out_valid cleared to 0.
  - Reset overrides every other input, including mid-stall.
- Forwarding (combinational, evaluated per source, separately for rs and rt):
  - If the source address is 0: use 0, never forwarded.
  - Else if ex_we and ex_addr matches and ex_load is 0: use ex_result.
  - Else if wb_we and wb_addr matches: use wb_data.
  - Otherwise: use rs_data or rt_data.
  - EX has priority over WB when both match.
- Immediate extension:
  - sign_ext=1 replicates imm16[15]; sign_ext=0 zero-fills.
  - Extension is to W bits; for W=32, imm16=0x8000 gives 0xFFFF8000 signed and 0x00008000 unsigned.
- Operand select: op2 source is the extended immediate when imm_sel=1, otherwise forwarded rt. op1 is always forwarded rs.
- Load-use hazard:
  - stall_req = in_valid & ex_load & ex_we & (ex_addr != 0) & (ex_addr == rs_addr | (ex_addr == rt_addr & ~imm_sel)).
  - The hazard persists until the load advances from EX to WB, so the stall lasts exactly 1 cycle.
- Register update priority each clock edge:
  1. rst: clear everything, as above.
  2. flush: insert a bubble.
  3. stall_req: insert a bubble.
  4. in_valid: capture the instruction.
  5. Otherwise: insert a bubble.
- Bubble:
  - aluop=00000, op1=op2=0, smt=0, rd_addr=0.
  - regwrite=0, is_load=0, out_valid=0.
  - aluop=00000 is the ALU default (passes op2), so a bubble yields r1=0 with no side effects.
- Capture: registered outputs take the forwarded and selected values; out_valid=1.
- Latency: exactly 1 cycle from capture to the ALU inputs. There is no internal buffering beyond one entry.
- Simultaneous events:
  - flush together with stall_req: bubble; stall_req is still asserted combinationally.
  - WB write in the same cycle as the regfile read: the WB forward covers regfile write-read ordering.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> all outputs 0, out_valid=0. Release -> next valid instruction appears after 1 cycle.
- Immediate: aluop_in=00001, rs=3 with rs_data=0x10, imm_sel=1, imm16=0xFFFE, sign_ext=1 -> op1=0x10, op2=0xFFFFFFFE. Repeat with sign_ext=0 -> op2=0x0000FFFE.
- Forward priority: rs=5, ex_we=1, ex_addr=5, ex_result=0xAA, wb_we=1, wb_addr=5, wb_data=0xBB -> op1=0xAA. Drop ex_we -> op1=0xBB. Set rs=0 with both paths matching address 0 -> op1=0.
- Load-use: ex_load=1, ex_we=1, ex_addr=7, rt=7, imm_sel=0 -> stall_req=1 and the next cycle holds a bubble (aluop=0, out_valid=0). Same case with imm_sel=1 and rs!=7 -> no stall.
- Flush: in_valid=1, regwrite_in=1, flush=1 -> next cycle regwrite=0, out_valid=0, aluop=0.
- Back-to-back: 4 consecutive valid instructions with no hazards -> each appears on the outputs one cycle later, in order, with out_valid held at 1.
